wave_meter: RTL
===============

Name: wave_meter

Overview:
- Measures the waveform coming back in on the PWM ADC path, i.e. the analysis end of the DDS-to-DAC signal chain.
- Consumes 8-bit ADC samples qualified by a valid strobe.
- Over a fixed gate window of iclk cycles it counts rising threshold crossings, using hysteresis, and tracks the sample maximum and minimum.
- At the end of each window it latches the frequency count, max, min and peak-to-peak, and pulses a result strobe. Runs on the 48 MHz PLL core clock.

Parameters:
- DATA_W, 8, sample width.
- GATE_CYCLES, 48_000_000, gate window length in iclk cycles (1 s at 48 MHz, so the count reads in Hz).
- GATE_W, 26, gate counter width; must satisfy 2^GATE_W > GATE_CYCLES.
- FREQ_W, 24, crossing counter width.
- MID, 8'd128, crossing threshold.
- HYST, 8'd8, hysteresis half-width.

Ports:
- iclk  in  1  system clock.
- irstn  in  1  asynchronous active-low reset.
- ienable  in  1  level; 1 = measure continuously, 0 = idle or abort.
- isample_valid  in  1  isample is valid this cycle.
- isample  in  DATA_W  unsigned ADC sample.
- ofreq_cnt  out  FREQ_W  rising crossings in the last completed window.
- omax  out  DATA_W  maximum sample in the last completed window.
- omin  out  DATA_W  minimum sample in the last completed window.
- ovpp  out  DATA_W  omax minus omin.
- operiod  out  GATE_W  cycles between the last two rising crossings (see optional feature).
- oresult_valid  out  1  one-cycle pulse when the result outputs update.
- obusy  out  1  high while in ARM or GATE.

Behaviour:
- Reset (async, irstn=0): all outputs 0; FSM to IDLE; all internal counters 0.
- Threshold arithmetic:
  - Computed in DATA_W+1 bits and saturated.
  - TH_HI = min(MID+HYST, 2^DATA_W−1).
  - TH_LO = max(MID−HYST, 0).
- FSM states:
  - IDLE: wait for ienable=1, then go to ARM.
  - ARM: on the first isample_valid, set max=min=isample and set the level flag to (isample >= MID).
    - Load gate_cnt=0 and crossing count=0, then go to GATE.
    - The arming sample counts as window cycle 0.
  - GATE: gate_cnt increments every iclk cycle. On each isample_valid:
    - update max/min (unsigned compare);
    - if level=0 and isample >= TH_HI: set level=1 and increment the crossing count, saturating at all-ones;
    - if level=1 and isample <= TH_LO: set level=0.
    - When gate_cnt == GATE_CYCLES−1, that cycle's sample is still included; next state is DONE.
  - DONE (1 cycle):
    - Latch ofreq_cnt, omax, omin, ovpp=max−min.
    - oresult_valid=1 for exactly this cycle.
    - Next state is ARM if ienable=1, else IDLE. Back-to-back windows have a 1-cycle gap plus the wait for the next valid sample.
- Abort: ienable=0 in ARM or GATE returns the FSM to IDLE on the next cycle. No oresult_valid pulse; result outputs keep their previous values.
- Latency: results appear the cycle after the last window cycle.
- Result outputs are stable between pulses.
- obusy is registered.
- A sample with isample_valid=0 is ignored entirely.
- No crossing can be counted on the arming sample.

Optional Feature:
- Macro WAVE_METER_PERIOD_EN.
- When defined:
  - A cycle stamp counter runs in GATE.
  - Each counted rising crossing records (stamp − previous stamp) once a previous crossing exists in the same window.
  - operiod is latched in DONE from the last recorded difference, or 0 if the window had fewer than 2 crossings.
- When undefined: operiod is tied to 0 and the stamp logic is absent.

Test Plan:
- Reset: assert irstn=0 mid-GATE → all outputs 0 immediately; after release with ienable=0, no oresult_valid pulse ever appears.
- Square wave: GATE_CYCLES=100, valid every cycle, 0x10 for 10 cycles then 0xF0 for 10, repeating → ofreq_cnt=5, omax=0xF0, omin=0x10, ovpp=0xE0, a single 1-cycle oresult_valid; operiod=20 with WAVE_METER_PERIOD_EN defined.
- Hysteresis reject: alternate 0x7C/0x84 every cycle, MID=128, HYST=8 → ofreq_cnt=0, ovpp=0x08; then 0x78/0x88 → crossing counted each period.
- Abort: ienable drops at window cycle 50 → FSM to IDLE, no pulse, previous results unchanged; reassert → fresh window measures correctly.
- Saturation: FREQ_W=4 with 20 crossings per window → ofreq_cnt=15. MID=250 → TH_HI=255, and a crossing is counted only on a sample of 255.
- Sparse valid: isample_valid every 4th cycle with a 40-cycle-period wave, GATE_CYCLES=200 → ofreq_cnt=5; invalid-cycle data of 0xFF is never reflected in omax.

Source files
------------

// File: rtl/wave_meter.sv
// wave_meter: gated ADC waveform analyser (rising-crossing count with hysteresis, max/min/p-p).
// Optional WAVE_METER_PERIOD_EN adds the last crossing-to-crossing period on operiod.
//
// state  | meaning
// IDLE   | not measuring, waiting for ienable
// ARM    | waiting for the first valid sample, which becomes window cycle 0
// GATE   | window running, one gate count per iclk
// DONE   | one-cycle gap after a window; result strobe is high here

module wave_meter #(
   parameter int                DATA_W      = 8,
   parameter int                GATE_CYCLES = 48_000_000,
   parameter int                GATE_W      = 26,
   parameter int                FREQ_W      = 24,
   parameter logic [DATA_W-1:0] MID         = 8'd128,
   parameter logic [DATA_W-1:0] HYST        = 8'd8
) (
   input  logic              iclk,
   input  logic              irstn,
   input  logic              ienable,
   input  logic              isample_valid,
   input  logic [DATA_W-1:0] isample,
   output logic [FREQ_W-1:0] ofreq_cnt,
   output logic [DATA_W-1:0] omax,
   output logic [DATA_W-1:0] omin,
   output logic [DATA_W-1:0] ovpp,
   output logic [GATE_W-1:0] operiod,
   output logic              oresult_valid,
   output logic              obusy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_GATE = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [DATA_W:0]   SUM_HI    = {1'b0, MID} + {1'b0, HYST};
   localparam logic [DATA_W-1:0] TH_HI     = SUM_HI[DATA_W] ? {DATA_W{1'b1}} : SUM_HI[DATA_W-1:0];
   localparam logic [DATA_W-1:0] TH_LO     = (MID >= HYST) ? (MID - HYST) : {DATA_W{1'b0}};
   localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

   logic [1:0]        r_state;
   logic [GATE_W-1:0] r_gate_cnt;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic              r_level;
   logic [FREQ_W-1:0] r_cross;

   logic [FREQ_W-1:0] r_freq;
   logic [DATA_W-1:0] r_omax;
   logic [DATA_W-1:0] r_omin;
   logic [DATA_W-1:0] r_vpp;
   logic              r_result_valid;
   logic              r_busy;

   logic [1:0]        w_state_nxt;
   logic              w_arm;
   logic              w_gate_run;
   logic              w_gate_end;
   logic [DATA_W-1:0] w_max_nxt;
   logic [DATA_W-1:0] w_min_nxt;
   logic              w_level_nxt;
   logic              w_cross_evt;
   logic [FREQ_W-1:0] w_cross_nxt;

   assign w_arm      = (r_state == S_ARM) && ienable && isample_valid;
   assign w_gate_run = (r_state == S_GATE) && ienable;
   assign w_gate_end = w_gate_run && (r_gate_cnt == GATE_LAST);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (ienable) w_state_nxt = S_ARM;
         S_ARM: begin
            if (!ienable)          w_state_nxt = S_IDLE;
            else if (isample_valid) w_state_nxt = S_GATE;
         end
         S_GATE: begin
            if (!ienable)       w_state_nxt = S_IDLE;
            else if (w_gate_end) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = ienable ? S_ARM : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Window statistics including the current sample; used while gating and for the final latch.
   always_comb begin
      w_max_nxt   = r_max;
      w_min_nxt   = r_min;
      w_level_nxt = r_level;
      w_cross_evt = 1'b0;
      w_cross_nxt = r_cross;
      if (isample_valid) begin
         if (isample > r_max) w_max_nxt = isample;
         if (isample < r_min) w_min_nxt = isample;
         if (!r_level && (isample >= TH_HI)) begin
            w_level_nxt = 1'b1;
            w_cross_evt = 1'b1;
         end else if (r_level && (isample <= TH_LO)) begin
            w_level_nxt = 1'b0;
         end
      end
      if (w_cross_evt && (r_cross != {FREQ_W{1'b1}})) w_cross_nxt = r_cross + 1'b1;
   end

   always_ff @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
         r_state        <= S_IDLE;
         r_gate_cnt     <= '0;
         r_max          <= '0;
         r_min          <= '0;
         r_level        <= 1'b0;
         r_cross        <= '0;
         r_freq         <= '0;
         r_omax         <= '0;
         r_omin         <= '0;
         r_vpp          <= '0;
         r_result_valid <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_busy         <= (w_state_nxt == S_ARM) || (w_state_nxt == S_GATE);
         r_result_valid <= w_gate_end;
         if (w_arm) begin
            // the arming sample already occupied window cycle 0
            r_gate_cnt <= GATE_W'(1);
            r_max      <= isample;
            r_min      <= isample;
            r_level    <= (isample >= MID);
            r_cross    <= '0;
         end else if (w_gate_run) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            r_max      <= w_max_nxt;
            r_min      <= w_min_nxt;
            r_level    <= w_level_nxt;
            r_cross    <= w_cross_nxt;
         end
         if (w_gate_end) begin
            r_freq <= w_cross_nxt;
            r_omax <= w_max_nxt;
            r_omin <= w_min_nxt;
            r_vpp  <= w_max_nxt - w_min_nxt;
         end
      end
   end

`ifdef WAVE_METER_PERIOD_EN
   logic [GATE_W-1:0] r_prev_stamp;
   logic [GATE_W-1:0] r_last_diff;
   logic [GATE_W-1:0] r_period;
   logic              r_have_prev;
   logic              r_have_diff;
   logic [GATE_W-1:0] w_diff;

   // The gate counter doubles as the crossing time stamp.
   assign w_diff = r_gate_cnt - r_prev_stamp;

   always_ff @(posedge iclk or negedge irstn) begin
      if (!irstn) begin
         r_prev_stamp <= '0;
         r_last_diff  <= '0;
         r_period     <= '0;
         r_have_prev  <= 1'b0;
         r_have_diff  <= 1'b0;
      end else begin
         if (w_arm) begin
            r_have_prev <= 1'b0;
            r_have_diff <= 1'b0;
         end else if (w_gate_run && w_cross_evt) begin
            if (r_have_prev) begin
               r_last_diff <= w_diff;
               r_have_diff <= 1'b1;
            end
            r_prev_stamp <= r_gate_cnt;
            r_have_prev  <= 1'b1;
         end
         if (w_gate_end) begin
            if (w_cross_evt && r_have_prev) r_period <= w_diff;
            else if (r_have_diff)           r_period <= r_last_diff;
            else                            r_period <= '0;
         end
      end
   end

   assign operiod = r_period;
`else
   assign operiod = '0;
`endif

   assign ofreq_cnt     = r_freq;
   assign omax          = r_omax;
   assign omin          = r_omin;
   assign ovpp          = r_vpp;
   assign oresult_valid = r_result_valid;
   assign obusy         = r_busy;

endmodule
